// File: rtl/dual_wb_queue_if.sv
// dual_wb_queue_if: retire-side push bundle and register-file drain bundle
// for the dual-issue writeback queue, plus its scoreboard/occupancy outputs.
interface dual_wb_queue_if #(
    parameter int AW = 2
);
    logic          flush;
    logic [1:0]    in_valid;
    logic [4:0]    in_addr1;
    logic [31:0]   in_data1;
    logic [4:0]    in_addr2;
    logic [31:0]   in_data2;
    logic          in_ready;
    logic          stall;
    logic [1:0]    reg_write_en;
    logic [4:0]    reg_write_addr1;
    logic [31:0]   reg_write_data1;
    logic [4:0]    reg_write_addr2;
    logic [31:0]   reg_write_data2;
    logic [31:0]   pending_mask;
    logic [AW:0]   count;

    modport master (
        output flush, in_valid, in_addr1, in_data1, in_addr2, in_data2,
        output stall,
        input  in_ready, reg_write_en, reg_write_addr1, reg_write_data1,
        input  reg_write_addr2, reg_write_data2, pending_mask, count
    );

    modport slave (
        input  flush, in_valid, in_addr1, in_data1, in_addr2, in_data2,
        input  stall,
        output in_ready, reg_write_en, reg_write_addr1, reg_write_data1,
        output reg_write_addr2, reg_write_data2, pending_mask, count
    );
endinterface

// File: rtl/dual_wb_queue.sv
// dual_wb_queue: 2-in/2-out writeback queue feeding the register file.
// Optional zero-latency empty-queue bypass when WB_QUEUE_BYPASS_EN is defined.
module dual_wb_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input logic clk,
    input logic rst,
    dual_wb_queue_if.slave bus
);
    localparam int CW = AW + 1;

    logic [4:0]    addr_q [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_sec;
    logic [AW-1:0] wr_sec;
    logic [AW:0]   count_q;
    logic [AW:0]   n_push;
    logic [AW:0]   n_pop;
    logic          ready;
    logic          acc0;
    logic          acc1;
    logic          st0;
    logic          st1;
    logic          pop0;
    logic          pop1;
    logic          bypass;
    logic          v0;
    logic          v1;

    // Push side: acceptance, x0 discard and storage slot selection
    always_comb begin
        ready = count_q <= CW'(DEPTH - 2);
        acc0 = ready && bus.in_valid[0] && (bus.in_addr1 != 5'd0);
        acc1 = ready && bus.in_valid[1] && (bus.in_addr2 != 5'd0);
`ifdef WB_QUEUE_BYPASS_EN
        bypass = (count_q == '0) && !bus.stall && acc0 && acc1;
`else
        bypass = 1'b0;
`endif
        st0 = acc0 && !bypass;
        st1 = acc1 && !bypass;
        wr_sec = wr_ptr + AW'(st0);
        n_push = CW'(st0) + CW'(st1);
    end

    // Drain side: present the two oldest entries (or bypassed inputs)
    always_comb begin
        rd_sec = rd_ptr + AW'(1);
        pop0 = !bus.stall && (count_q >= CW'(1));
        pop1 = !bus.stall && (count_q >= CW'(2));
        n_pop = CW'(pop0) + CW'(pop1);
        v0 = pop0;
        v1 = pop1;
        bus.reg_write_addr1 = addr_q[rd_ptr];
        bus.reg_write_data1 = data_q[rd_ptr];
        bus.reg_write_addr2 = addr_q[rd_sec];
        bus.reg_write_data2 = data_q[rd_sec];
        if (bypass) begin
            v0 = 1'b1;
            v1 = 1'b1;
            bus.reg_write_addr1 = bus.in_addr1;
            bus.reg_write_data1 = bus.in_data1;
            bus.reg_write_addr2 = bus.in_addr2;
            bus.reg_write_data2 = bus.in_data2;
        end
        // younger write wins when both target the same register
        bus.reg_write_en[1] = v1;
        bus.reg_write_en[0] = v0 && !(v1 &&
            (bus.reg_write_addr1 == bus.reg_write_addr2));
        bus.in_ready = ready;
        bus.count = count_q;
    end

    // Scoreboard: one-hot destination of every occupied slot
    always_comb begin
        logic [AW-1:0] off;
        bus.pending_mask = '0;
        off = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = AW'(i) - rd_ptr;
            if ({1'b0, off} < count_q)
                bus.pending_mask[addr_q[i]] = 1'b1;
        end
        bus.pending_mask[0] = 1'b0;
    end

    // Pointer and occupancy update; flush and reset empty the queue
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count_q <= '0;
        end else begin
            rd_ptr <= rd_ptr + AW'(n_pop);
            wr_ptr <= wr_ptr + AW'(n_push);
            count_q <= count_q + n_push - n_pop;
        end
    end

    // Entry storage writes in program order
    always_ff @(posedge clk) begin
        if (!rst && !bus.flush) begin
            if (st0) begin
                addr_q[wr_ptr] <= bus.in_addr1;
                data_q[wr_ptr] <= bus.in_data1;
            end
            if (st1) begin
                addr_q[wr_sec] <= bus.in_addr2;
                data_q[wr_sec] <= bus.in_data2;
            end
        end
    end
endmodule
